// File: rtl/conv_window_collector.sv
// Collects per-pixel convolution results, keeps only windows fully inside the image,
// and presents them through a small show-ahead FIFO tagged with output-map coordinates.
module conv_window_collector #(
    parameter int DATA_WIDTH = 16,
    parameter int F          = 3,
    parameter int IMG_WIDTH  = 8,
    parameter int IMG_HEIGHT = 8,
    parameter int COORD_W    = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  iValid,
    input  logic [DATA_WIDTH-1:0] iData,
    output logic                  oValid,
    input  logic                  oReady,
    output logic [DATA_WIDTH-1:0] oData,
    output logic [COORD_W-1:0]    oRow,
    output logic [COORD_W-1:0]    oCol,
    output logic                  oFrameDone,
    output logic                  oOverflow,
    input  logic                  iClear
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [COORD_W-1:0] EDGE     = COORD_W'(F - 1);
    localparam logic [COORD_W-1:0] LAST_COL = COORD_W'(IMG_WIDTH - 1);
    localparam logic [COORD_W-1:0] LAST_ROW = COORD_W'(IMG_HEIGHT - 1);
    localparam logic [CNT_W-1:0]   FULL_CNT = CNT_W'(FIFO_DEPTH);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic [COORD_W-1:0]    row;
        logic [COORD_W-1:0]    col;
    } entry_t;

    logic [COORD_W-1:0] col_q, col_d;
    logic [COORD_W-1:0] row_q, row_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [CNT_W-1:0]   remaining;
    entry_t             head_q, head_d;
    entry_t             new_entry;
    entry_t             mem_q [FIFO_DEPTH];
    logic               valid_q, valid_d;
    logic               frame_done_q, frame_done_d;
    logic               overflow_q, overflow_d;

    logic in_bounds;
    logic push_req;
    logic full;
    logic pop;
    logic push;
    logic mem_we;
    logic at_last_col;
    logic at_last_row;

    always_comb begin
        in_bounds   = (row_q >= EDGE) && (col_q >= EDGE);
        push_req    = iValid && in_bounds;
        full        = (count_q == FULL_CNT);
        pop         = valid_q && oReady;
        // A full FIFO still accepts a push when the head leaves in the same cycle.
        push        = push_req && (!full || pop);
        mem_we      = push && !iClear;
        at_last_col = (col_q == LAST_COL);
        at_last_row = (row_q == LAST_ROW);

        new_entry.data = iData;
        new_entry.row  = row_q - EDGE;
        new_entry.col  = col_q - EDGE;

        col_d = col_q;
        row_d = row_q;
        if (iValid) begin
            if (at_last_col) begin
                col_d = '0;
                row_d = at_last_row ? '0 : row_q + COORD_W'(1);
            end else begin
                col_d = col_q + COORD_W'(1);
            end
        end

        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;

        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
        end
        remaining = pop ? count_q - CNT_W'(1) : count_q;

        // The head register is refilled from storage, or straight from the input
        // when the FIFO is about to become (or stay) otherwise empty.
        head_d = head_q;
        if (count_d != '0) begin
            head_d = (remaining == '0) ? new_entry : mem_q[rd_ptr_d];
        end

        valid_d      = (count_d != '0);
        overflow_d   = overflow_q || (push_req && full && !pop);
        frame_done_d = iValid && at_last_col && at_last_row;

        if (iClear) begin
            col_d        = '0;
            row_d        = '0;
            wr_ptr_d     = '0;
            rd_ptr_d     = '0;
            count_d      = '0;
            head_d       = head_q;
            valid_d      = 1'b0;
            overflow_d   = 1'b0;
            frame_done_d = 1'b0;
        end
    end

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q        <= '0;
            row_q        <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            head_q       <= '0;
            valid_q      <= 1'b0;
            frame_done_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            head_q       <= head_d;
            valid_q      <= valid_d;
            frame_done_q <= frame_done_d;
            overflow_q   <= overflow_d;
        end
    end

    // NOTE: storage is not reset; count_q and head_q alone decide what is visible.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[wr_ptr_q] <= new_entry;
        end
    end

    assign oValid     = valid_q;
    assign oData      = head_q.data;
    assign oRow       = head_q.row;
    assign oCol       = head_q.col;
    assign oFrameDone = frame_done_q;
    assign oOverflow  = overflow_q;

endmodule

// File: tb/tb_conv_window_collector.sv
// Self-checking bench for conv_window_collector: a queue-based reference model
// compared every cycle, plus hand-computed expectations for the directed scenarios.
module tb_conv_window_collector;

    localparam int DW = 16;
    localparam int F  = 3;
    localparam int W  = 8;
    localparam int H  = 8;
    localparam int CW = 8;
    localparam int D  = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          iValid = 1'b0;
    logic [DW-1:0] iData = '0;
    logic          oValid;
    logic          oReady = 1'b0;
    logic [DW-1:0] oData;
    logic [CW-1:0] oRow;
    logic [CW-1:0] oCol;
    logic          oFrameDone;
    logic          oOverflow;
    logic          iClear = 1'b0;

    conv_window_collector #(
        .DATA_WIDTH(DW), .F(F), .IMG_WIDTH(W), .IMG_HEIGHT(H), .COORD_W(CW), .FIFO_DEPTH(D)
    ) dut (
        .clk(clk), .rst_n(rst_n), .iValid(iValid), .iData(iData),
        .oValid(oValid), .oReady(oReady), .oData(oData), .oRow(oRow), .oCol(oCol),
        .oFrameDone(oFrameDone), .oOverflow(oOverflow), .iClear(iClear)
    );

    always #5 clk = ~clk;

    typedef struct {
        int data;
        int row;
        int col;
    } ent_t;

    ent_t mq[$];
    ent_t got[$];
    int   pix = 0;
    bit   m_ovf = 1'b0;
    bit   m_fd = 1'b0;
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   fd_cnt = 0;
    int   fd_cyc = -1;
    int   first_valid = -1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_clear();
        mq.delete();
        pix   = 0;
        m_ovf = 1'b0;
        m_fd  = 1'b0;
    endtask

    task automatic compare();
        check("valid", oValid, mq.size() > 0);
        if (mq.size() > 0) begin
            check("data", oData, mq[0].data);
            check("row", oRow, mq[0].row);
            check("col", oCol, mq[0].col);
        end
        check("frame_done", oFrameDone, m_fd);
        check("overflow", oOverflow, m_ovf);
    endtask

    // One clock: drive, update the model at the edge, sample 1ns later.
    task automatic cycle(input bit v, input int d, input bit rdy, input bit clr);
        bit pop;
        bit full;
        bit inb;
        ent_t e;
        iValid = v;
        iData  = DW'(d);
        oReady = rdy;
        iClear = clr;
        if (oValid && rdy && !clr) got.push_back('{int'(oData), int'(oRow), int'(oCol)});
        @(posedge clk);
        if (clr) begin
            model_clear();
        end else begin
            pop  = (mq.size() > 0) && rdy;
            inb  = v && (pix / W >= F - 1) && (pix % W >= F - 1);
            full = (mq.size() == D);
            if (pop) e = mq.pop_front();
            if (inb) begin
                if (!full || pop) mq.push_back('{d & 16'hFFFF, pix / W - (F - 1), pix % W - (F - 1)});
                else m_ovf = 1'b1;
            end
            m_fd = v && (pix == W * H - 1);
            if (v) pix = (pix + 1) % (W * H);
        end
        #1;
        cyc++;
        if (oFrameDone) begin
            fd_cnt++;
            fd_cyc = cyc;
        end
        if (oValid && first_valid < 0) first_valid = cyc;
        compare();
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) cycle(1'b0, 0, rdy, 1'b0);
    endtask

    task automatic clear_all();
        cycle(1'b0, 0, 1'b1, 1'b1);
        got.delete();
        fd_cnt      = 0;
        fd_cyc      = -1;
        first_valid = -1;
    endtask

    task automatic check_got(input string name, input int idx, input int d, input int r, input int c);
        ent_t e;
        e = (idx < got.size()) ? got[idx] : '{-1, -1, -1};
        check({name, "_data"}, e.data, d);
        check({name, "_row"}, e.row, r);
        check({name, "_col"}, e.col, c);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k18_cyc;
        int k63_cyc;
        int mism;
        int exp_list[$];

        #12;
        check("rst_valid", oValid, 0);
        check("rst_data", oData, 0);
        check("rst_row", oRow, 0);
        check("rst_col", oCol, 0);
        check("rst_fd", oFrameDone, 0);
        check("rst_ovf", oOverflow, 0);
        rst_n = 1'b1;

        // Full frame, always ready.
        clear_all();
        k18_cyc = 0;
        k63_cyc = 0;
        for (int k = 0; k < 64; k++) begin
            if (k == 18) k18_cyc = cyc + 1;
            if (k == 63) k63_cyc = cyc + 1;
            cycle(1'b1, k, 1'b1, 1'b0);
        end
        idle(4, 1'b1);
        check("f1_count", got.size(), 36);
        check_got("f1_first", 0, 18, 0, 0);
        check_got("f1_last", 35, 63, 5, 5);
        check("f1_first_valid_cyc", first_valid, k18_cyc);
        check("f1_fd_count", fd_cnt, 1);
        check("f1_fd_cyc", fd_cyc, k63_cyc);

        // Same frame with a bubble after every pixel.
        for (int k = 0; k < 64; k++) if (k / W >= 2 && k % W >= 2) exp_list.push_back(k);
        clear_all();
        for (int k = 0; k < 64; k++) begin
            cycle(1'b1, k, 1'b1, 1'b0);
            cycle(1'b0, int'($urandom_range(0, 65535)), 1'b1, 1'b0);
        end
        idle(4, 1'b1);
        check("gap_count", got.size(), 36);
        mism = 0;
        for (int i = 0; i < 36; i++) if (i >= got.size() || got[i].data != exp_list[i]) mism++;
        check("gap_order_mismatches", mism, 0);
        check("gap_ovf", oOverflow, 0);

        // Downstream stalled for the whole frame.
        clear_all();
        for (int k = 0; k < 64; k++) begin
            cycle(1'b1, k, 1'b0, 1'b0);
            if (k == 21) check("stall_ovf_before", oOverflow, 0);
            if (k == 22) check("stall_ovf_after", oOverflow, 1);
        end
        check("stall_head_valid", oValid, 1);
        check("stall_head_data", oData, 18);
        idle(8, 1'b1);
        check("stall_count", got.size(), 4);
        for (int i = 0; i < 4; i++) check_got("stall_out", i, 18 + i, 0, i);
        check("empty_hold_valid", oValid, 0);
        check("empty_hold_data", oData, 21);
        check("empty_hold_col", oCol, 3);
        check("stall_ovf_sticky", oOverflow, 1);

        // Push into a full FIFO while the head is popped.
        clear_all();
        for (int k = 0; k < 22; k++) cycle(1'b1, k, 1'b0, 1'b0);
        cycle(1'b1, 22, 1'b1, 1'b0);
        idle(8, 1'b1);
        check("fullpop_ovf", oOverflow, 0);
        check("fullpop_count", got.size(), 5);
        for (int i = 0; i < 4; i++) check_got("fullpop_out", i, 18 + i, 0, i);
        check_got("fullpop_new", 4, 22, 0, 4);

        // Two frames back to back.
        clear_all();
        for (int k = 0; k < 128; k++) cycle(1'b1, k, 1'b1, 1'b0);
        idle(4, 1'b1);
        check("f2_count", got.size(), 72);
        check_got("f2_first", 36, 82, 0, 0);
        check_got("f2_last", 71, 127, 5, 5);
        check("f2_fd_count", fd_cnt, 2);

        // Synchronous clear mid-frame, with iValid asserted in the same cycle.
        clear_all();
        for (int k = 0; k <= 30; k++) cycle(1'b1, k, 1'b1, 1'b0);
        cycle(1'b1, 999, 1'b1, 1'b1);
        check("clr_valid", oValid, 0);
        check("clr_ovf", oOverflow, 0);
        got.delete();
        for (int j = 0; j < 19; j++) cycle(1'b1, 100 + j, 1'b1, 1'b0);
        idle(3, 1'b1);
        check_got("clr_restart", 0, 118, 0, 0);

        // Asynchronous reset mid-frame with a stalled, overflowed FIFO.
        clear_all();
        for (int k = 0; k <= 40; k++) cycle(1'b1, k, 1'b0, 1'b0);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_valid", oValid, 0);
        check("arst_data", oData, 0);
        check("arst_row", oRow, 0);
        check("arst_col", oCol, 0);
        check("arst_fd", oFrameDone, 0);
        check("arst_ovf", oOverflow, 0);
        model_clear();
        got.delete();
        #2;
        rst_n = 1'b1;
        for (int j = 0; j < 19; j++) cycle(1'b1, 200 + j, 1'b1, 1'b0);
        idle(3, 1'b1);
        check_got("arst_restart", 0, 218, 0, 0);

        // Random soak: gaps, backpressure and occasional clears.
        clear_all();
        for (int i = 0; i < 1500; i++) begin
            cycle($urandom_range(0, 3) != 0, int'($urandom_range(0, 65535)),
                  $urandom_range(0, 2) != 0, $urandom_range(0, 199) == 0);
        end
        idle(8, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
